jtag_master: RTL and testbench
==============================

Name: jtag_master

Overview:
- Host-side JTAG sequencer. It accepts scan commands (TAP reset, IR scan, DR scan, idle clocks) over a valid/ready interface and generates TCK/TMS/TDI from the system clock.
- It samples TDO and returns the captured bits on a response channel.
- It drives the on-chip TAP (tap_fsm + IR + IDCODE/bypass/BS/I-Mem/scan-chain DRs) for self-test and I-Mem loading.
- It tracks the TAP state internally and parks in Run-Test/Idle between commands.

Parameters:
- DIV, 2, clk cycles per TCK half-period (>=1).
- MAX_LEN, 32, maximum scan length in bits; sets the data width.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  0=RESET, 1=IR, 2=DR, 3=IDLE
- cmd_len_i  in  5  bit count minus 1 (0..31 -> 1..32); for IDLE, the number of TCKs minus 1
- cmd_data_i  in  MAX_LEN  TDI data, LSB shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  MAX_LEN  captured TDO bits, right-aligned
- tck_o  out  1  JTAG test clock
- tms_o  out  1  test mode select
- tdi_o  out  1  test data to target
- tdo_i  in  1  test data from target

Behaviour:
- Reset values: tck_o=0, tms_o=1, tdi_o=0, rsp_valid_o=0, rsp_data_o=0, cmd_ready_o=1.
- Reset also clears the internal sync flag and returns the controller to IDLE.
- Asserting rst_n_i mid-command aborts the command immediately. No response is issued.

TCK slots:
- One slot = 2*DIV clk cycles. Low phase first, then high phase.
- tms_o and tdi_o update on the clk edge that starts the slot, which is also when tck_o falls.
- tck_o rises DIV cycles later. tdo_i is sampled on that same clk edge.
- tck_o is parked low in IDLE and RSP.

State machine: IDLE, TRST, PRE, SHIFT, POST, RUN, RSP.
- IDLE: cmd_ready_o=1. On accept, latch op, len and data, then branch:
  - op=RESET, or sync flag=0 with any op: go to TRST.
  - otherwise: go to PRE (IR, DR) or RUN (IDLE op).
- TRST: 6 slots, TMS=1,1,1,1,1,0 (ends in Run-Test/Idle).
  - Sets the sync flag.
  - op=RESET: go to RSP. Otherwise go to the op's normal path.
- PRE: TMS sequence 1,0,0 for DR, or 1,1,0,0 for IR. TDI=0. Then go to SHIFT.
- SHIFT: len+1 slots.
  - tdi_o = data[k] in slot k.
  - TMS=0 in every slot except the last, which has TMS=1 (Exit1).
  - The bit sampled in slot k goes to capture[k].
- POST: 2 slots, TMS=1,0 (Update, then Run-Test/Idle). Then go to RSP.
- RUN: len+1 slots with TMS=0 and TDI=0. Then go to RSP.
- RSP: rsp_valid_o=1 until rsp_ready_i.
  - rsp_data_o = capture, with bits above len zero.
  - RESET and IDLE ops return 0.
  - cmd_ready_o=0 while in RSP. Exit to IDLE on handshake.
  - No new command is accepted in the handshake cycle.

Slot totals:
- RESET: 6
- DR: len+6 (using the 5-bit field value)
- IR: len+7
- IDLE: len+1
- Add 6 if an auto-reset is prepended.

Other rules:
- Exactly one response is issued per accepted command.
- cmd_* inputs are ignored outside IDLE.
- Boundaries:
  - len=0 is a 1-bit scan, which enters Exit1 in its only shift slot.
  - len=31 gives a full 32-bit scan.
  - DIV=1 gives a 2-clk TCK period.

Decomposition:
- Shared package (jtag_pack, alongside as_pack):
  - jtag_op_t enum for RESET/IR/DR/IDLE.
  - Constants: TRST_SLOTS=6, PRE_DR_TMS=3'b001, PRE_IR_TMS=4'b0011 (LSB first).
  - Reuse ir_width for IR scans.
- Sub-module jtag_tck_gen:
  - Divider with an enable input.
  - Outputs tck_o, slot_start (fall strobe) and sample (rise strobe).
  - Resets to tck low with the counter cleared.

Test Plan:
- RESET command, DIV=2 -> TMS 1,1,1,1,1,0 at 6 consecutive TCK rises, TCK period 4 clk, rsp_data=0, one rsp.
- First command after rst_n_i is IR len=7 (8 bits) data 0x01, with jtag as target -> 6 auto-reset slots, then TMS 1,1,0,0, 7 zeros, 1, then 1,0; rsp_data=0xF1 (IR capture value).
- IR 0x01 (IDCODE), then DR len=31 data 0 -> rsp_data=0xDEADBEEF; TCK parked low afterwards.
- IR BYPASS, then DR len=7 data 0xA5 -> rsp_data=0x4A (one-bit bypass delay, first bit 0).
- Hold rsp_ready_i=0 for 20 clk with cmd_valid_i=1 -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0, TCK idle low. After the handshake, the next command starts.
- Assert rst_n_i low in the middle of a DR scan -> outputs go to reset values at once, no rsp. The next DR command is preceded by the 6-slot reset sequence.

Source files
------------

// File: rtl/jtag_master_pkg.sv
// rtl/jtag_master_pkg.sv - shared JTAG sequencer types and TMS sequences
package jtag_master_pkg;

   typedef enum logic [1:0] {
      OP_RESET = 2'd0,
      OP_IR    = 2'd1,
      OP_DR    = 2'd2,
      OP_IDLE  = 2'd3
   } jtag_op_t;

   // TMS sequences are stored LSB first: bit k is driven in slot k.
   localparam int         TRST_SLOTS = 6;
   localparam logic [5:0] TRST_TMS   = 6'b011111;
   localparam logic [2:0] PRE_DR_TMS = 3'b001;
   localparam logic [3:0] PRE_IR_TMS = 4'b0011;

   function automatic logic pre_tms(input jtag_op_t op, input logic [1:0] idx);
      logic [3:0] w_seq;
      w_seq = (op == OP_IR) ? PRE_IR_TMS : {1'b0, PRE_DR_TMS};
      return w_seq[idx];
   endfunction

   function automatic logic [4:0] pre_last(input jtag_op_t op);
      return (op == OP_IR) ? 5'd3 : 5'd2;
   endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// rtl/jtag_master_tck_gen.sv - TCK divider with slot-start (fall) and sample (rise) strobes
module jtag_master_tck_gen #(
   parameter int DIV = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic en_i,
   output logic tck_o,
   output logic slot_start_o,
   output logic sample_o
);
   localparam int         CW   = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(2 * DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(DIV);

   logic [CW-1:0] r_cnt;
   logic          r_tck;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else if (!en_i) begin
         r_cnt <= '0;
         r_tck <= 1'b0;
      end else begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
         if (r_cnt == '0)
            r_tck <= 1'b0;
         else if (r_cnt == HALF)
            r_tck <= 1'b1;
      end
   end

   assign tck_o        = r_tck;
   assign slot_start_o = en_i && (r_cnt == '0);
   assign sample_o     = en_i && (r_cnt == HALF);

endmodule

// File: rtl/jtag_master.sv
// rtl/jtag_master.sv - host-side JTAG sequencer: RESET/IR/DR/IDLE commands to TCK/TMS/TDI
module jtag_master
   import jtag_master_pkg::*;
#(
   parameter int DIV     = 2,
   parameter int MAX_LEN = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic [1:0]         cmd_op_i,
   input  logic [4:0]         cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
   input  logic               tdo_i
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_TRST  = 3'd1;
   localparam logic [2:0] S_PRE   = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_POST  = 3'd4;
   localparam logic [2:0] S_RUN   = 3'd5;
   localparam logic [2:0] S_RSP   = 3'd6;

   logic [2:0]         r_state;
   jtag_op_t           r_op;
   logic [4:0]         r_len;
   logic [4:0]         r_idx;
   logic [MAX_LEN-1:0] r_data;
   logic [MAX_LEN-1:0] r_capture;
   logic               r_sync;
   logic               r_last;
   logic               r_tms;
   logic               r_tdi;

   logic     w_en;
   logic     w_slot_start;
   logic     w_sample;
   logic     w_tms;
   logic     w_tdi;
   jtag_op_t w_op;

   assign w_op = jtag_op_t'(cmd_op_i);
   assign w_en = (r_state != S_IDLE) && (r_state != S_RSP);

   jtag_master_tck_gen #(.DIV(DIV)) u_tck_gen (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .en_i         (w_en),
      .tck_o        (tck_o),
      .slot_start_o (w_slot_start),
      .sample_o     (w_sample)
   );

   always_comb begin
      w_tms = 1'b0;
      w_tdi = 1'b0;
      case (r_state)
         S_TRST:  w_tms = TRST_TMS[r_idx[2:0]];
         S_PRE:   w_tms = pre_tms(r_op, r_idx[1:0]);
         S_SHIFT: begin
            w_tms = (r_idx == r_len);
            w_tdi = r_data[r_idx];
         end
         S_POST:  w_tms = (r_idx == 5'd0);
         default: w_tms = 1'b0;
      endcase
   end

   // Slot bookkeeping advances on the TCK rise; r_last lets the final high phase
   // run its full length before the controller parks in RSP at the next fall.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state   <= S_IDLE;
         r_op      <= OP_RESET;
         r_len     <= '0;
         r_idx     <= '0;
         r_data    <= '0;
         r_capture <= '0;
         r_sync    <= 1'b0;
         r_last    <= 1'b0;
         r_tms     <= 1'b1;
         r_tdi     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  r_op      <= w_op;
                  r_len     <= cmd_len_i;
                  r_data    <= cmd_data_i;
                  r_capture <= '0;
                  r_idx     <= '0;
                  r_last    <= 1'b0;
                  if (w_op == OP_RESET || !r_sync)
                     r_state <= S_TRST;
                  else if (w_op == OP_IDLE)
                     r_state <= S_RUN;
                  else
                     r_state <= S_PRE;
               end
            end
            S_RSP: begin
               if (rsp_ready_i)
                  r_state <= S_IDLE;
            end
            default: begin
               if (w_slot_start) begin
                  if (r_last) begin
                     r_state <= S_RSP;
                     r_last  <= 1'b0;
                     r_tdi   <= 1'b0;
                  end else begin
                     r_tms <= w_tms;
                     r_tdi <= w_tdi;
                  end
               end
               if (w_sample && !r_last) begin
                  case (r_state)
                     S_TRST: begin
                        if (r_idx == 5'(TRST_SLOTS - 1)) begin
                           r_idx  <= '0;
                           r_sync <= 1'b1;
                           if (r_op == OP_RESET)
                              r_last <= 1'b1;
                           else
                              r_state <= (r_op == OP_IDLE) ? S_RUN : S_PRE;
                        end else begin
                           r_idx <= r_idx + 5'd1;
                        end
                     end
                     S_PRE: begin
                        if (r_idx == pre_last(r_op)) begin
                           r_idx   <= '0;
                           r_state <= S_SHIFT;
                        end else begin
                           r_idx <= r_idx + 5'd1;
                        end
                     end
                     S_SHIFT: begin
                        r_capture[r_idx] <= tdo_i;
                        if (r_idx == r_len) begin
                           r_idx   <= '0;
                           r_state <= S_POST;
                        end else begin
                           r_idx <= r_idx + 5'd1;
                        end
                     end
                     S_POST: begin
                        if (r_idx == 5'd1)
                           r_last <= 1'b1;
                        else
                           r_idx <= r_idx + 5'd1;
                     end
                     S_RUN: begin
                        if (r_idx == r_len)
                           r_last <= 1'b1;
                        else
                           r_idx <= r_idx + 5'd1;
                     end
                     default: r_idx <= r_idx;
                  endcase
               end
            end
         endcase
      end
   end

   assign cmd_ready_o = (r_state == S_IDLE);
   assign rsp_valid_o = (r_state == S_RSP);
   assign rsp_data_o  = r_capture;
   assign tms_o       = r_tms;
   assign tdi_o       = r_tdi;

endmodule

// File: tb/tb_jtag_master.sv
// tb/tb_jtag_master.sv - directed bench for jtag_master with a behavioural TAP target
module tb_jtag_master;
   localparam int  DIV  = 2;
   localparam time TCLK = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_len;
   logic [31:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        tck, tms, tdi;
   logic        tdo;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [31:0] exp_data[$];
   logic [63:0] exp_tms[$];
   int          exp_n[$];
   logic        rise_tms[$];
   time         rise_t[$];

   always #(TCLK / 2) clk = ~clk;

   jtag_master #(.DIV(DIV), .MAX_LEN(32)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_op_i    (cmd_op),
      .cmd_len_i   (cmd_len),
      .cmd_data_i  (cmd_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .tck_o       (tck),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .tdo_i       (tdo)
   );

   // Behavioural TAP: IR resets to IDCODE (0x01), IR capture 0xF1, any other IR selects bypass.
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6, EX2DR = 7;
   localparam int UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

   int          tap_st = TLR;
   logic [7:0]  tap_ir = 8'h01;
   logic [31:0] tap_sr = '0;
   logic        tap_tdo = 1'b0;

   function automatic int tap_next(input int st, input logic m);
      case (st)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PAUDR;
         PAUDR: return m ? EX2DR : PAUDR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAUIR;
         PAUIR: return m ? EX2IR : PAUIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      rise_tms.push_back(tms);
      rise_t.push_back($time);
      case (tap_st)
         TLR:   tap_ir <= 8'h01;
         CAPDR: tap_sr <= (tap_ir == 8'h01) ? 32'hDEADBEEF : 32'h0;
         SHDR:  tap_sr <= (tap_ir == 8'h01) ? {tdi, tap_sr[31:1]} : {31'h0, tdi};
         CAPIR: tap_sr <= 32'h0000_00F1;
         SHIR:  tap_sr <= {24'h0, tdi, tap_sr[7:1]};
         UPIR:  tap_ir <= tap_sr[7:0];
         default: tap_sr <= tap_sr;
      endcase
      tap_st <= tap_next(tap_st, tms);
   end

   always @(negedge tck)
      tap_tdo <= (tap_st == SHDR || tap_st == SHIR) ? tap_sr[0] : 1'b0;

   assign tdo = tap_tdo;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [4:0] len, input logic [31:0] data,
                          input logic [31:0] exp, input bit auto_rst, input bit hold, input string tag);
      logic [63:0] e_tms, o_tms, e_pop;
      logic [31:0] d_pop, snap;
      int          e_n, o_n, st, bad, n_pop;
      bit          got;
      e_tms = '0;
      e_n   = 0;
      if (auto_rst || op == 2'd0)
         for (int i = 0; i < 6; i++) begin e_tms[e_n] = (i < 5); e_n++; end
      if (op == 2'd1) begin e_tms[e_n] = 1'b1; e_tms[e_n+1] = 1'b1; e_n += 4; end
      if (op == 2'd2) begin e_tms[e_n] = 1'b1; e_n += 3; end
      if (op == 2'd1 || op == 2'd2) begin
         e_n += int'(len);
         e_tms[e_n] = 1'b1;
         e_tms[e_n+1] = 1'b1;
         e_n += 3;
      end
      if (op == 2'd3) e_n += int'(len) + 1;
      exp_data.push_back(exp);
      exp_tms.push_back(e_tms);
      exp_n.push_back(e_n);

      @(negedge clk);
      st        = rise_tms.size();
      rsp_ready = !hold;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_len   = len;
      cmd_data  = data;
      got = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (cmd_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;

      got = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         if (rsp_valid) begin got = 1'b1; break; end
         @(negedge clk);
      end
      d_pop = exp_data.pop_front();
      e_pop = exp_tms.pop_front();
      n_pop = exp_n.pop_front();
      if (!got) begin
         chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
         return;
      end
      o_n   = rise_tms.size() - st;
      o_tms = '0;
      bad   = 0;
      for (int i = 0; i < o_n && i < 64; i++) o_tms[i] = rise_tms[st+i];
      for (int i = 1; i < o_n; i++)
         if (rise_t[st+i] - rise_t[st+i-1] != 2 * DIV * TCLK) bad++;
      chk({tag, "_data"},     64'(rsp_data), 64'(d_pop));
      chk({tag, "_slots"},    64'(o_n),      64'(n_pop));
      chk({tag, "_tms"},      o_tms,         e_pop);
      chk({tag, "_tck_period"}, 64'(bad),    64'd0);
      chk({tag, "_tck_park"}, 64'(tck),      64'd0);

      if (hold) begin
         snap      = rsp_data;
         cmd_valid = 1'b1;
         cmd_op    = 2'd2;
         cmd_len   = 5'd3;
         bad       = 0;
         repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== snap || cmd_ready !== 1'b0 || tck !== 1'b0) bad++;
         end
         chk({tag, "_hold_stable"}, 64'(bad), 64'd0);
         cmd_valid = 1'b0;
         rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_one_rsp"},   64'(rsp_valid), 64'd0);
      chk({tag, "_ready_back"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      int bad;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_len   = 5'd0;
      cmd_data  = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tck",       64'(tck),       64'd0);
      chk("rst_tms",       64'(tms),       64'd1);
      chk("rst_tdi",       64'(tdi),       64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data",  64'(rsp_data),  64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      rst_n = 1'b1;

      run_cmd(2'd1, 5'd7,  32'h01,  32'hF1,       1'b1, 1'b0, "ir_autorst");
      run_cmd(2'd0, 5'd0,  32'h0,   32'h0,        1'b0, 1'b0, "reset");
      run_cmd(2'd1, 5'd7,  32'h01,  32'hF1,       1'b0, 1'b0, "ir_idcode");
      run_cmd(2'd2, 5'd31, 32'h0,   32'hDEADBEEF, 1'b0, 1'b0, "dr_idcode");
      run_cmd(2'd1, 5'd7,  32'hFF,  32'hF1,       1'b0, 1'b0, "ir_bypass");
      run_cmd(2'd2, 5'd7,  32'hA5,  32'h4A,       1'b0, 1'b0, "dr_bypass");
      run_cmd(2'd2, 5'd0,  32'h1,   32'h0,        1'b0, 1'b0, "dr_len0");
      run_cmd(2'd3, 5'd4,  32'h0,   32'h0,        1'b0, 1'b1, "idle_hold");
      run_cmd(2'd3, 5'd0,  32'h0,   32'h0,        1'b0, 1'b0, "idle_len0");

      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_len   = 5'd31;
      cmd_data  = 32'h0;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_tck",       64'(tck),       64'd0);
      chk("abort_tms",       64'(tms),       64'd1);
      chk("abort_tdi",       64'(tdi),       64'd0);
      chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) bad++;
      end
      chk("abort_no_rsp", 64'(bad), 64'd0);
      rst_n = 1'b1;
      run_cmd(2'd2, 5'd31, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, "dr_after_abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
